// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and flag-vector indices shared by the ALU pipeline
package alu_pkg;

  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD  = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB  = 6'b100010;
  localparam logic [OPW-1:0] OP_AND  = 6'b100100;
  localparam logic [OPW-1:0] OP_OR   = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR  = 6'b100110;
  localparam logic [OPW-1:0] OP_NOR  = 6'b100111;
  localparam logic [OPW-1:0] OP_SLL  = 6'b000000;
  localparam logic [OPW-1:0] OP_SRL  = 6'b000010;
  localparam logic [OPW-1:0] OP_SRA  = 6'b000011;
  localparam logic [OPW-1:0] OP_SLT  = 6'b101010;
  localparam logic [OPW-1:0] OP_SLTU = 6'b101011;
  localparam logic [OPW-1:0] OP_MUL  = 6'b011000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLAG_NEG   = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ILL   = 4;
  localparam int NUM_FLAGS  = 5;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/opcode input handshake and result/flag output handshake of alu_pipe
interface alu_pipe_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_a;
  logic [DATA_WIDTH-1:0] i_b;
  logic [OP_WIDTH-1:0]   i_op;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_result;
  logic                  o_negative;
  logic                  o_zero;
  logic                  o_carry;
  logic                  o_overflow;
  logic                  o_illegal;

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_ready,
    output o_ready, o_valid, o_result, o_negative, o_zero, o_carry, o_overflow, o_illegal
  );

  modport master (
    output i_valid, i_a, i_b, i_op, i_ready,
    input  o_ready, o_valid, o_result, o_negative, o_zero, o_carry, o_overflow, o_illegal
  );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational result and flags for every single-cycle opcode
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] result,
  output logic [NUM_FLAGS-1:0]  flags
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic [SHW-1:0]      shamt;
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;
  logic                carry;
  logic                ovf;
  logic                illegal;

  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    flags   = '0;
    case (op)
      OP_ADD: begin
        result = sum[MSB:0];
        carry  = sum[DATA_WIDTH];
        ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow.
        result = diff[MSB:0];
        carry  = ~diff[DATA_WIDTH];
        ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: illegal = 1'b1;
    endcase
    flags[FLAG_NEG]   = result[MSB];
    flags[FLAG_ZERO]  = (result == '0);
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_ILL]   = illegal;
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU; ALU_PIPE_MUL_EN adds an iterative shift-add multiplier
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic      i_clk,
  input  logic      i_reset,
  alu_pipe_if.slave bus
);
  state_t                state_q;
  state_t                state_d;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [NUM_FLAGS-1:0]  flags_q;
  logic [DATA_WIDTH-1:0] core_result;
  logic [NUM_FLAGS-1:0]  core_flags;
  logic [DATA_WIDTH-1:0] mul_result;
  logic [NUM_FLAGS-1:0]  mul_flags;
  logic                  out_free;
  logic                  ready;
  logic                  accept;
  logic                  is_mul;
  logic                  load_mul;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .OP_WIDTH  (OP_WIDTH)
  ) u_core (
    .a     (bus.i_a),
    .b     (bus.i_b),
    .op    (bus.i_op),
    .result(core_result),
    .flags (core_flags)
  );

  // The output register frees up in the same cycle it drains, so a new op can land on top.
  assign out_free = !valid_q || bus.i_ready;
  assign ready    = (state_q == ST_IDLE) && out_free;
  assign accept   = bus.i_valid && ready;

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         mcand_q;
  logic [PW-1:0]         prod_q;
  logic [PW-1:0]         prod_step;
  logic [PW-1:0]         prod_final;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [CW-1:0]         cnt_q;
  logic                  mul_done;
  logic                  mul_last;

  assign is_mul     = (bus.i_op == OP_MUL);
  assign mul_done   = (cnt_q == CW'(DATA_WIDTH));
  assign mul_last   = mul_done || (cnt_q == CW'(DATA_WIDTH - 1));
  assign prod_step  = prod_q + (mplier_q[0] ? mcand_q : '0);
  // The last partial product goes straight to the output register when it is free;
  // otherwise it is parked in prod_q and the counter stays at done.
  assign prod_final = mul_done ? prod_q : prod_step;
  assign load_mul   = (state_q == ST_MUL) && mul_last && out_free;

  always_ff @(posedge i_clk) begin
    if (accept && is_mul) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, bus.i_a};
      mplier_q <= bus.i_b;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if ((state_q == ST_MUL) && !mul_done) begin
      prod_q   <= prod_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    mul_flags             = '0;
    mul_result            = prod_final[DATA_WIDTH-1:0];
    mul_flags[FLAG_NEG]   = prod_final[DATA_WIDTH-1];
    mul_flags[FLAG_ZERO]  = (prod_final[DATA_WIDTH-1:0] == '0);
    mul_flags[FLAG_CARRY] = |prod_final[PW-1:DATA_WIDTH];
  end
`else
  assign is_mul     = 1'b0;
  assign load_mul   = 1'b0;
  assign mul_result = '0;
  assign mul_flags  = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (load_mul) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (accept && !is_mul) begin
      valid_q <= 1'b1;
      res_q   <= core_result;
      flags_q <= core_flags;
    end else if (load_mul) begin
      valid_q <= 1'b1;
      res_q   <= mul_result;
      flags_q <= mul_flags;
    end else if (valid_q && bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_result   = res_q;
  assign bus.o_negative = flags_q[FLAG_NEG];
  assign bus.o_zero     = flags_q[FLAG_ZERO];
  assign bus.o_carry    = flags_q[FLAG_CARRY];
  assign bus.o_overflow = flags_q[FLAG_OVF];
  assign bus.o_illegal  = flags_q[FLAG_ILL];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [5:0] T_ADD  = 6'b100000;
  localparam logic [5:0] T_SUB  = 6'b100010;
  localparam logic [5:0] T_AND  = 6'b100100;
  localparam logic [5:0] T_OR   = 6'b100101;
  localparam logic [5:0] T_XOR  = 6'b100110;
  localparam logic [5:0] T_NOR  = 6'b100111;
  localparam logic [5:0] T_SLL  = 6'b000000;
  localparam logic [5:0] T_SRL  = 6'b000010;
  localparam logic [5:0] T_SRA  = 6'b000011;
  localparam logic [5:0] T_SLT  = 6'b101010;
  localparam logic [5:0] T_SLTU = 6'b101011;
  localparam logic [5:0] T_MUL  = 6'b011000;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  flags;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_pop;
  exp_t sb_q[$];
  logic hold_pending;
  logic [7:0] held_res;
  logic [4:0] held_flags;
  logic [5:0] op_tab [13];

  alu_pipe_if #(.DATA_WIDTH(8),  .OP_WIDTH(6)) bus8();
  alu_pipe_if #(.DATA_WIDTH(16), .OP_WIDTH(6)) bus16();

  alu_pipe #(.DATA_WIDTH(8),  .OP_WIDTH(6)) dut8  (.i_clk(clk), .i_reset(rst), .bus(bus8));
  alu_pipe #(.DATA_WIDTH(16), .OP_WIDTH(6)) dut16 (.i_clk(clk), .i_reset(rst), .bus(bus16));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {illegal, overflow, carry, zero, negative}.
  function automatic exp_t model(int w, longint a, longint b, logic [5:0] op);
    exp_t   e;
    longint m, half, sa, sb, full, res;
    int     sh;
    bit     c, v, ill;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    sh   = int'(b % w);
    res  = 0; c = 0; v = 0; ill = 0;
    case (op)
      T_ADD: begin
        full = a + b; res = full % m; c = (full >= m);
        v = (sa + sb >= half) || (sa + sb < -half);
      end
      T_SUB: begin
        res = (a - b + m) % m; c = (a >= b);
        v = (sa - sb >= half) || (sa - sb < -half);
      end
      T_AND:  res = a & b;
      T_OR:   res = a | b;
      T_XOR:  res = a ^ b;
      T_NOR:  res = ~(a | b) & (m - 1);
      T_SLL:  res = (a * (longint'(1) << sh)) % m;
      T_SRL:  res = a / (longint'(1) << sh);
      T_SRA:  res = ((sa >>> sh) + m) % m;
      T_SLT:  res = (sa < sb) ? 1 : 0;
      T_SLTU: res = (a < b) ? 1 : 0;
      T_MUL: begin
        if (MUL_EN) begin
          full = a * b; res = full % m; c = (full >= m);
        end else begin
          ill = 1;
        end
      end
      default: ill = 1;
    endcase
    e.res   = 64'(res);
    e.flags = {ill, v, c, (res == 0), (res >= half)};
    return e;
  endfunction

  function automatic logic [4:0] flags8();
    return {bus8.o_illegal, bus8.o_overflow, bus8.o_carry, bus8.o_zero, bus8.o_negative};
  endfunction

  function automatic logic [4:0] flags16();
    return {bus16.o_illegal, bus16.o_overflow, bus16.o_carry, bus16.o_zero, bus16.o_negative};
  endfunction

  // One clock of the streaming scoreboard; called just after a rising edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [5:0] op, input logic rdy, output logic acc);
    exp_t e;
    bus8.i_valid = v; bus8.i_a = a; bus8.i_b = b; bus8.i_op = op; bus8.i_ready = rdy;
    #1;
    if (hold_pending)
      check_eq("hold", {bus8.o_valid, bus8.o_result, flags8()}, {1'b1, held_res, held_flags});
    if (bus8.o_valid && !rdy)
      check_eq("bp_ready", bus8.o_ready, 0);
    acc = v && bus8.o_ready;
    if (bus8.o_valid && rdy) begin
      if (sb_q.size() == 0) begin
        check_eq("extra_result", 1, 0);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        check_eq("sb_res", bus8.o_result, e.res);
        check_eq("sb_flags", flags8(), e.flags);
      end
    end
    hold_pending = bus8.o_valid && !rdy;
    held_res     = bus8.o_result;
    held_flags   = flags8();
    if (acc) sb_q.push_back(model(8, a, b, op));
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    exp_t e;
    int   lat;
    int   lat_exp;
    logic saw_ready;
    e       = model(8, a, b, op);
    lat_exp = (op == T_MUL && MUL_EN) ? 8 : 1;
    bus8.i_valid = 1; bus8.i_a = a; bus8.i_b = b; bus8.i_op = op; bus8.i_ready = 0;
    #1;
    check_eq({tag, "_accept"}, bus8.o_ready, 1);
    @(posedge clk); #1;
    bus8.i_valid = 0;
    bus8.i_a = 8'($urandom);
    bus8.i_b = 8'($urandom);
    bus8.i_op = 6'($urandom);
    lat = 1;
    saw_ready = 0;
    while (!bus8.o_valid && lat < 40) begin
      saw_ready |= bus8.o_ready;
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, lat_exp);
    check_eq({tag, "_busy_ready"}, saw_ready, 0);
    check_eq({tag, "_res"}, bus8.o_result, e.res);
    check_eq({tag, "_flags"}, flags8(), e.flags);
    bus8.i_ready = 1;
    @(posedge clk); #1;
    bus8.i_ready = 0;
    check_eq({tag, "_drained"}, bus8.o_valid, 0);
  endtask

  task automatic do_op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    exp_t e;
    e = model(16, a, b, op);
    bus16.i_valid = 1; bus16.i_a = a; bus16.i_b = b; bus16.i_op = op;
    @(posedge clk); #1;
    bus16.i_valid = 0;
    check_eq({tag, "_valid"}, bus16.o_valid, 1);
    check_eq({tag, "_res"}, bus16.o_result, e.res);
    check_eq({tag, "_flags"}, flags16(), e.flags);
    @(posedge clk); #1;
  endtask

  initial begin
    logic acc;
    int   sent;
    int   pops0;
    int   cyc;
    logic saw_valid;
    clk = 0; rst = 1;
    n_checks = 0; n_fail = 0; n_pop = 0;
    hold_pending = 0; held_res = 0; held_flags = 0;
    op_tab = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SLL, T_SRL, T_SRA, T_SLT, T_SLTU, T_MUL, 6'b111111};
    bus8.i_valid = 0; bus8.i_a = 0; bus8.i_b = 0; bus8.i_op = 0; bus8.i_ready = 0;
    bus16.i_valid = 0; bus16.i_a = 0; bus16.i_b = 0; bus16.i_op = 0; bus16.i_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    check_eq("rst_state", {bus8.o_valid, bus8.o_result, flags8()}, 0);
    check_eq("rst_ready", bus8.o_ready, 1);

    do_op("add_ovf",  8'h7F, 8'h01, T_ADD);
    do_op("add_wrap", 8'hFF, 8'h01, T_ADD);
    do_op("sub",      8'h05, 8'h07, T_SUB);
    do_op("slt",      8'hFE, 8'h01, T_SLT);
    do_op("sltu",     8'hFE, 8'h01, T_SLTU);
    do_op("sra",      8'h80, 8'h09, T_SRA);
    do_op("sll",      8'h01, 8'h07, T_SLL);
    do_op("mul_ff",   8'h0F, 8'h11, T_MUL);
    do_op("mul_c",    8'h10, 8'h10, T_MUL);
    do_op("illegal",  8'h5A, 8'hA5, 6'b111111);

    // Backpressure: four ADDs, consumer stalls for three cycles after the first is accepted.
    pops0 = n_pop;
    sent  = 0;
    cyc   = 0;
    while (sent < 4 && cyc < 50) begin
      step(1'b1, 8'($urandom), 8'($urandom), T_ADD, !(cyc >= 1 && cyc <= 3), acc);
      if (acc) sent++;
      cyc++;
    end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step(1'b0, 0, 0, T_ADD, 1'b1, acc);
    check_eq("bp_count", n_pop - pops0, 4);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
           ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 12)],
           $urandom_range(0, 9) < 6, acc);
    for (int i = 0; i < 100 && sb_q.size() > 0; i++) step(1'b0, 0, 0, T_ADD, 1'b1, acc);
    check_eq("drain_empty", sb_q.size(), 0);
    hold_pending = 0;

    // Reset in the middle of a multiply must abort it without leaving a result behind.
    bus8.i_valid = 1; bus8.i_a = 8'h0F; bus8.i_b = 8'h11; bus8.i_op = T_MUL; bus8.i_ready = 0;
    @(posedge clk); #1;
    bus8.i_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    check_eq("mrst_state", {bus8.o_valid, bus8.o_result, flags8()}, 0);
    check_eq("mrst_ready", bus8.o_ready, 1);
    bus8.i_ready = 1;
    saw_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      saw_valid |= bus8.o_valid;
    end
    check_eq("mrst_stale", saw_valid, 0);
    bus8.i_ready = 0;

    do_op16("w16_add",  16'h007F, 16'h0001, T_ADD);
    do_op16("w16_wrap", 16'hFFFF, 16'h0001, T_ADD);
    do_op16("w16_ovf",  16'h7FFF, 16'h0001, T_ADD);
    do_op16("w16_sra",  16'hFF80, 16'h0009, T_SRA);
    do_op16("w16_sra1", 16'h8000, 16'h0011, T_SRA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, flow-controlled ALU: parametrised successor of the team's combinational 8-bit ALU. Accepts one operation per cycle through a valid/ready handshake, holds result and flags in an output register until consumed, and adds signed overflow, SLL, SLT/SLTU and an optional iterative multiplier. Sits between the operand/opcode source (switch/UART front-end or datapath decode) and the result consumer.

## Interface
- DATA_WIDTH, 8, operand/result width; power of two, ≥ 4
- OP_WIDTH, 6, opcode width (MIPS funct encoding)
- i_clk  in  1  single clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  operand/opcode presented
- o_ready  out  1  block can accept this cycle
- i_a, i_b  in  DATA_WIDTH  operands
- i_op  in  OP_WIDTH  opcode
- o_valid  out  1  result register holds an unconsumed result
- i_ready  in  1  consumer takes result this cycle
- o_result  out  DATA_WIDTH  result
- o_negative, o_zero, o_carry, o_overflow  out  1 each  flags
- o_illegal  out  1  opcode not recognised

## Operation
- Opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000000 SLL, 000010 SRL, 000011 SRA, 101010 SLT (signed), 101011 SLTU; 011000 MUL when enabled.
- Shift amount = i_b[$clog2(DATA_WIDTH)-1:0]; upper bits ignored.
- ADD: DATA_WIDTH+1-bit sum; o_carry = carry out; o_overflow = operands same sign, result sign differs.
- SUB: o_carry = 1 when i_a ≥ i_b unsigned (no borrow); o_overflow = operand signs differ, result sign differs from i_a.
- SLT/SLTU: result = {0…0, lt}.
- o_carry, o_overflow = 0 for all other ops. o_zero = (result == 0); o_negative = result MSB; computed for every op.
- Unrecognised opcode: result 0, o_zero = 1, o_illegal = 1; still handshakes normally.
- Handshake: transfer in when i_valid && o_ready; out when o_valid && i_ready.
- FSM: IDLE (accepting), MUL (iterating, only with multiplier). Reset → IDLE.
- o_ready = state==IDLE && (!o_valid || i_ready); accepts same cycle an output drains (full throughput).
- Inputs sampled only at transfer; need not be held afterwards.
- Output register and flags stable while o_valid && !i_ready.

## Timing
- Reset: o_valid 0, o_result 0, all flags 0, o_illegal 0, state IDLE; o_ready 1 the cycle after reset deasserts. Reset mid-multiply aborts it, no result emitted.
- Single-cycle ops: accepted at edge N → o_valid and result visible after edge N (1-cycle latency); back-to-back 1 op/cycle with i_ready held high.
- MUL: accept at edge N → MUL state for DATA_WIDTH cycles (shift-add, one bit per cycle) → o_valid after edge N+DATA_WIDTH; o_ready 0 throughout MUL state.
- MUL waiting to write while o_valid && !i_ready: FSM stays in MUL with counter done until output register free; no result lost or overwritten.
- o_ready is combinational from state, o_valid, i_ready; no path from i_valid to o_ready.

## Configuration
- ALU_PIPE_MUL_EN defined: MUL opcode 011000 legal; result = low DATA_WIDTH bits of unsigned product; o_carry = 1 if upper product half nonzero; o_overflow 0; MUL state present.
- Undefined: no multiplier logic, FSM degenerates to IDLE only; 011000 treated as illegal (result 0, o_illegal 1).

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD … OP_MUL), state encoding, flag-vector index constants.
- Sub-module alu_core: combinational result/flag compute for single-cycle ops (widened generation of existing ALU, plus overflow, SLL, SLT/SLTU, illegal). alu_pipe owns handshake, output register, FSM and multiplier datapath.

## Test plan
- Reset: assert i_reset 2 cycles mid-MUL → outputs all 0, o_valid 0, o_ready 1 after release, no stale result.
- ADD 8'h7F+8'h01 → 8'h80, negative 1, overflow 1, carry 0; ADD 8'hFF+8'h01 → 8'h00, zero 1, carry 1, overflow 0; latency 1 cycle.
- SUB 8'h05−8'h07 → 8'hFE, carry 0, negative 1; SLT 8'hFE,8'h01 → 1; SLTU same → 0; SRA 8'h80 by 8'h09 (amount 1) → 8'hC0; SLL 8'h01 by 7 → 8'h80.
- Backpressure: stream 4 ADDs, hold i_ready 0 for 3 cycles after first → o_ready 0, first result held stable, remaining results in order, none dropped or duplicated.
- MUL (macro on, DATA_WIDTH 8): 8'h0F×8'h11 → 8'hFF carry 0 after 8 cycles, o_ready low meanwhile; 8'h10×8'h10 → 8'h00, zero 1, carry 1. Macro off: same opcode → o_illegal 1, result 0, 1-cycle latency.
- Illegal opcode 6'b111111 → result 0, zero 1, illegal 1; DATA_WIDTH=16 rerun of ADD/SRA vectors sign-extended.
